// File: rtl/fetch_seq_if.sv
// Control/fetch bundle between the instruction decoder and the fetch sequencer.
// The slave modport is the sequencer side; master is the environment driving control.
interface fetch_seq_if #(
    parameter int unsigned IW = 9
);
    logic          Start;
    logic          Halt;
    logic          Stall;
    logic          BranchEn;
    logic          BranchRel;
    logic [IW-1:0] Target;
    logic [IW-1:0] InstAddress;
    logic          InstValid;
    logic          Done;
    logic [15:0]   CycleCount;

    modport master (
        output Start, Halt, Stall, BranchEn, BranchRel, Target,
        input  InstAddress, InstValid, Done, CycleCount
    );

    modport slave (
        input  Start, Halt, Stall, BranchEn, BranchRel, Target,
        output InstAddress, InstValid, Done, CycleCount
    );
endinterface

// File: rtl/fetch_seq.sv
// Program-counter sequencer: IDLE/RUN/DONE FSM with halt, stall and abs/rel branches.
// Optional run-cycle counter enabled by defining FETCH_SEQ_CYCLE_COUNT_EN.
module fetch_seq #(
    parameter int unsigned    IW         = 9,
    parameter logic [IW-1:0]  START_ADDR = '0
) (
    input logic        Clk,
    input logic        Reset,
    fetch_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [IW-1:0] pc_q;
    logic          valid_q;
    logic          done_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= START_ADDR;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pc_q <= START_ADDR;
                    if (bus.Start) begin
                        state_q <= StRun;
                        valid_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    // Halt outranks stall and branch in the same cycle.
                    if (bus.Halt) begin
                        state_q <= StDone;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bus.Stall) begin
                        pc_q <= pc_q;
                    end else if (bus.BranchEn) begin
                        pc_q <= bus.BranchRel ? pc_q + bus.Target : bus.Target;
                    end else begin
                        pc_q <= pc_q + IW'(1);
                    end
                end
                StDone: begin
                    if (bus.Start) begin
                        state_q <= StRun;
                        pc_q    <= START_ADDR;
                        valid_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    pc_q    <= START_ADDR;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstValid   = valid_q;
    assign bus.Done        = done_q;

`ifdef FETCH_SEQ_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= 16'h0000;
        end else if ((state_q != StRun) && bus.Start) begin
            cnt_q <= 16'h0000;
        end else if ((state_q == StRun) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign bus.CycleCount = cnt_q;
`else
    assign bus.CycleCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: vector table through a scoreboard queue,
// plus hand-written sequences for async reset and the cycle counter.
module tb_fetch_seq;
    localparam int unsigned IW = 9;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fails;

    fetch_seq_if #(.IW(IW)) bus ();

    fetch_seq #(.IW(IW), .START_ADDR(9'd0)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic          start;
        logic          halt;
        logic          stall;
        logic          br_en;
        logic          br_rel;
        logic [IW-1:0] target;
        logic [IW-1:0] exp_addr;
        logic          exp_valid;
        logic          exp_done;
    } vec_t;

    typedef struct {
        logic [IW-1:0] addr;
        logic          valid;
        logic          done;
        int            idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic h, input logic st, input logic be,
                         input logic br, input logic [IW-1:0] t);
        bus.Start     = s;
        bus.Halt      = h;
        bus.Stall     = st;
        bus.BranchEn  = be;
        bus.BranchRel = br;
        bus.Target    = t;
    endtask

    task automatic add(input logic s, input logic h, input logic st, input logic be,
                       input logic br, input logic [IW-1:0] t, input logic [IW-1:0] ea,
                       input logic ev, input logic ed);
        vec_t v;
        v = '{s, h, st, be, br, t, ea, ev, ed};
        vecs.push_back(v);
    endtask

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic apply(input int idx);
        exp_t e;
        exp_t got;
        @(negedge Clk);
        drive(vecs[idx].start, vecs[idx].halt, vecs[idx].stall, vecs[idx].br_en,
              vecs[idx].br_rel, vecs[idx].target);
        e = '{vecs[idx].exp_addr, vecs[idx].exp_valid, vecs[idx].exp_done, idx};
        sb.push_back(e);
        @(posedge Clk);
        #1;
        got = sb.pop_front();
        check($sformatf("vec%0d addr", got.idx), 32'(bus.InstAddress), 32'(got.addr));
        check($sformatf("vec%0d valid", got.idx), 32'(bus.InstValid), 32'(got.valid));
        check($sformatf("vec%0d done", got.idx), 32'(bus.Done), 32'(got.done));
    endtask

    task automatic step(input logic s, input logic h, input logic st, input logic be,
                        input logic br, input logic [IW-1:0] t);
        @(negedge Clk);
        drive(s, h, st, be, br, t);
        @(posedge Clk);
        #1;
    endtask

    logic [15:0] exp_cnt6;

    initial begin
        n_checks = 0;
        n_fails  = 0;
`ifdef FETCH_SEQ_CYCLE_COUNT_EN
        exp_cnt6 = 16'd6;
`else
        exp_cnt6 = 16'd0;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        Reset = 1'b1;
        #12;
        check("reset addr", 32'(bus.InstAddress), 32'd0);
        check("reset valid", 32'(bus.InstValid), 32'd0);
        check("reset done", 32'(bus.Done), 32'd0);
        check("reset count", 32'(bus.CycleCount), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        //   start halt stall br_en br_rel target   addr   valid done
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd50,  9'd0,   1'b0, 1'b0); // branch in IDLE ignored
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd1,   1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd2,   1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd3,   1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd4,   1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd5,   1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd99,  9'd5,   1'b1, 1'b0); // stall beats branch
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd10,  9'd10,  1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd200, 9'd200, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1FE, 9'd198, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd511, 9'd511, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   1'b1, 1'b0); // wrap
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd5,   9'd5,   1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h1FA, 9'd511, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd7,   9'd7,   1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd100, 9'd7,   1'b0, 1'b1); // halt wins
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd100, 9'd7,   1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd0,   1'b1, 1'b0); // restart
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0,   9'd1,   1'b1, 1'b0); // start ignored in RUN
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd42,  9'd42,  1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) apply(i);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-cycle while running at PC=42.
        @(negedge Clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        #2;
        Reset = 1'b1;
        #1;
        check("async reset addr", 32'(bus.InstAddress), 32'd0);
        check("async reset valid", 32'(bus.InstValid), 32'd0);
        check("async reset done", 32'(bus.Done), 32'd0);
        check("async reset count", 32'(bus.CycleCount), 32'd0);
        #1;
        Reset = 1'b0;
        bus.Start = 1'b1;
        @(posedge Clk);
        #1;
        check("first start valid", 32'(bus.InstValid), 32'd1);
        check("first start addr", 32'(bus.InstAddress), 32'd0);

        // Cycle counter: start, 3 run, 2 stall, halt.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("halt done", 32'(bus.Done), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("restart count clear", 32'(bus.CycleCount), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("run addr", 32'(bus.InstAddress), 32'd3);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("stall addr", 32'(bus.InstAddress), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("count at done", 32'(bus.CycleCount), 32'(exp_cnt6));
        check("done flag", 32'(bus.Done), 32'd1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd33);
        check("count held", 32'(bus.CycleCount), 32'(exp_cnt6));
        check("addr held in done", 32'(bus.InstAddress), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
